// File: rtl/seg7_scan_if.sv
// Bus between a multiplexed 7-segment display driver and the scan decoder.
// SEG7_DP_EN adds the decimal-point input and the per-digit point mask.
interface seg7_scan_if #(
    parameter int unsigned NDIG = 4
);
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_en;
    logic [4*NDIG-1:0] value;
    logic              value_valid;
    logic [NDIG-1:0]   blank_mask;
    logic              pat_err;
`ifdef SEG7_DP_EN
    logic              seg_dp;
    logic [NDIG-1:0]   dp_mask;

    modport master (
        output seg_in, dig_en, seg_dp,
        input  value, value_valid, blank_mask, pat_err, dp_mask
    );
    modport slave (
        input  seg_in, dig_en, seg_dp,
        output value, value_valid, blank_mask, pat_err, dp_mask
    );
`else
    modport master (
        output seg_in, dig_en,
        input  value, value_valid, blank_mask, pat_err
    );
    modport slave (
        input  seg_in, dig_en,
        output value, value_valid, blank_mask, pat_err
    );
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment display and rebuilds the shown hex frame.
// Define SEG7_DP_EN to also capture the decimal point of each digit.
module seg7_scan_decoder #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 8
) (
    input logic          clk,
    input logic          rst_n,
    seg7_scan_if.slave   bus
);
    localparam int unsigned IdxW = $clog2(NDIG);
`ifdef SEG7_DP_EN
    localparam int unsigned PatW = 8;
`else
    localparam int unsigned PatW = 7;
`endif
    localparam logic [7:0] StableCyc = 8'(STABLE_CYC);

    typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

    logic [PatW-1:0] pat_in;
`ifdef SEG7_DP_EN
    assign pat_in = {bus.seg_dp, bus.seg_in};
`else
    assign pat_in = bus.seg_in;
`endif

    logic [PatW-1:0]        pat_s1_q, pat_s2_q;
    logic [NDIG-1:0]        dig_s1_q, dig_s2_q;
    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [PatW-1:0]        pat_q, pat_d;
    logic [NDIG-1:0]        dig_q, dig_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NDIG-1:0]        captured_q, captured_d;
    logic [NDIG-1:0][3:0]   shadow_q;
    logic [NDIG-1:0]        blank_sh_q;
    logic [4*NDIG-1:0]      value_q;
    logic [NDIG-1:0]        blank_q;
    logic                   valid_q;
    logic                   perr_q;

    logic [NDIG-1:0] dig_act;
    logic            one_hot;
    logic [IdxW-1:0] dig_idx;
    logic            changed;
    logic            accept;
    logic            code_ok;
    logic            code_blank;
    logic [3:0]      code_nib;
    logic            frame_done;

    assign dig_act = ~dig_s2_q;
    assign one_hot = (dig_act != '0) && ((dig_act & (dig_act - NDIG'(1))) == '0);
    assign changed = (dig_s2_q != dig_q) || (pat_s2_q != pat_q);

    always_comb begin
        dig_idx = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (dig_act[i]) dig_idx = IdxW'(i);
        end
    end

    // Leaving IDLE, a change in SETTLE and a change in HELD all follow the same rule.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if ((state_q == StIdle) || changed) begin
            dig_d = dig_s2_q;
            pat_d = pat_s2_q;
            if (one_hot) begin
                state_d = StSettle;
                idx_d   = dig_idx;
                cnt_d   = 8'd1;
            end else begin
                state_d = StIdle;
            end
        end else if (state_q == StSettle) begin
            if (cnt_q < StableCyc) cnt_d = cnt_q + 8'd1;
            if (cnt_q >= StableCyc - 8'd1) begin
                accept  = 1'b1;
                state_d = StHeld;
            end
        end
    end

    always_comb begin
        code_ok    = 1'b1;
        code_blank = 1'b0;
        code_nib   = 4'h0;
        case (pat_q[6:0])
            7'b1000000: code_nib = 4'h0;
            7'b1111001: code_nib = 4'h1;
            7'b0100100: code_nib = 4'h2;
            7'b0110000: code_nib = 4'h3;
            7'b0011001: code_nib = 4'h4;
            7'b0010010: code_nib = 4'h5;
            7'b0000010: code_nib = 4'h6;
            7'b1111000: code_nib = 4'h7;
            7'b0000000: code_nib = 4'h8;
            7'b0010000: code_nib = 4'h9;
            7'b0001000: code_nib = 4'hA;
            7'b0000011: code_nib = 4'hB;
            7'b0100111: code_nib = 4'hC;
            7'b0100001: code_nib = 4'hD;
            7'b0000110: code_nib = 4'hE;
            7'b1111111: begin
                code_nib   = 4'hF;
                code_blank = 1'b1;
            end
            default:    code_ok = 1'b0;
        endcase
    end

    // A digit accepted on the frame-complete cycle belongs to the next frame.
    assign frame_done = &captured_q;
    always_comb begin
        captured_d = frame_done ? '0 : captured_q;
        if (accept && code_ok) captured_d[idx_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_s1_q   <= '1;
            pat_s2_q   <= '1;
            dig_s1_q   <= '1;
            dig_s2_q   <= '1;
            state_q    <= StIdle;
            idx_q      <= '0;
            pat_q      <= '0;
            dig_q      <= '1;
            cnt_q      <= '0;
            captured_q <= '0;
            shadow_q   <= '0;
            blank_sh_q <= '0;
            value_q    <= '0;
            blank_q    <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            pat_s1_q   <= pat_in;
            pat_s2_q   <= pat_s1_q;
            dig_s1_q   <= bus.dig_en;
            dig_s2_q   <= dig_s1_q;
            state_q    <= state_d;
            idx_q      <= idx_d;
            pat_q      <= pat_d;
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            if (accept && code_ok) begin
                shadow_q[idx_q]   <= code_nib;
                blank_sh_q[idx_q] <= code_blank;
            end
            if (frame_done) begin
                value_q <= shadow_q;
                blank_q <= blank_sh_q;
            end
            valid_q <= frame_done;
            perr_q  <= accept && !code_ok;
        end
    end

`ifdef SEG7_DP_EN
    logic [NDIG-1:0] dp_sh_q, dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_sh_q <= '0;
            dp_q    <= '0;
        end else begin
            if (accept && code_ok) dp_sh_q[idx_q] <= ~pat_q[PatW-1];
            if (frame_done) dp_q <= dp_sh_q;
        end
    end

    assign bus.dp_mask = dp_q;
`endif

    assign bus.value       = value_q;
    assign bus.blank_mask  = blank_q;
    assign bus.value_valid = valid_q;
    assign bus.pat_err     = perr_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=4, STABLE_CYC=8).
module tb_seg7_scan_decoder;
    localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000, P0 = 7'b1000000, PBLANK = 7'b1111111;
    localparam logic [6:0] PA = 7'b0001000, PB = 7'b0000011, PC = 7'b0100111;
    localparam logic [6:0] PD = 7'b0100001, PBAD = 7'b1010101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   vv_cnt = 0;
    int   pe_cnt = 0;
    int   vv_base;
    int   pe_base;

    seg7_scan_if #(.NDIG(4)) bus ();

    seg7_scan_decoder #(
        .NDIG       (4),
        .STABLE_CYC (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.value_valid === 1'b1) vv_cnt++;
        if (bus.pat_err === 1'b1) pe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int ncyc);
        bus.dig_en = ~(4'b0001 << idx);
        bus.seg_in = pat;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic idle(input int ncyc);
        bus.dig_en = 4'hF;
        bus.seg_in = PBLANK;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic mark();
        vv_base = vv_cnt;
        pe_base = pe_cnt;
    endtask

    initial begin
        bus.dig_en = 4'hF;
        bus.seg_in = PBLANK;
`ifdef SEG7_DP_EN
        bus.seg_dp = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_valid", 32'(bus.value_valid), 32'h0);
        check("rst_blank", 32'(bus.blank_mask), 32'h0);
        check("rst_perr", 32'(bus.pat_err), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Digits 0..3 show 1,2,3,4
        mark();
        show(0, P1, 16); show(1, P2, 16); show(2, P3, 16); show(3, P4, 16);
        idle(10);
        check("t1_vv", 32'(vv_cnt - vv_base), 32'd1);
        check("t1_value", 32'(bus.value), 32'h4321);
        check("t1_blank", 32'(bus.blank_mask), 32'h0);
        check("t1_perr", 32'(pe_cnt - pe_base), 32'd0);

        // Blank digit 2
        mark();
        show(0, P8, 16); show(1, P8, 16); show(2, PBLANK, 16); show(3, P8, 16);
        idle(10);
        check("t2_vv", 32'(vv_cnt - vv_base), 32'd1);
        check("t2_value", 32'(bus.value), 32'h8F88);
        check("t2_blank", 32'(bus.blank_mask), 32'h4);

        // Invalid pattern on digit 1, then rescan it valid
        mark();
        show(0, P0, 16); show(1, PBAD, 16); show(2, P0, 16); show(3, P0, 16);
        idle(10);
        check("t3_perr", 32'(pe_cnt - pe_base), 32'd1);
        check("t3_vv_none", 32'(vv_cnt - vv_base), 32'd0);
        check("t3_value_hold", 32'(bus.value), 32'h8F88);
        show(1, P5, 16);
        idle(10);
        check("t3_vv", 32'(vv_cnt - vv_base), 32'd1);
        check("t3_value", 32'(bus.value), 32'h0050);

        // One cycle short of STABLE_CYC per digit
        mark();
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 4; d++) show(d, P8, 7);
        end
        idle(10);
        check("t4_vv", 32'(vv_cnt - vv_base), 32'd0);
        check("t4_perr", 32'(pe_cnt - pe_base), 32'd0);
        check("t4_captured", 32'(dut.captured_q), 32'h0);

        // Exactly STABLE_CYC per digit is enough
        mark();
        show(0, PA, 8); show(1, PB, 8); show(2, PC, 8); show(3, PD, 8);
        idle(10);
        check("t4b_vv", 32'(vv_cnt - vv_base), 32'd1);
        check("t4b_value", 32'(bus.value), 32'hDCBA);
        check("t4b_blank", 32'(bus.blank_mask), 32'h0);

        // Two strobes low at once
        mark();
        bus.dig_en = 4'b0011;
        bus.seg_in = P8;
        repeat (50) @(negedge clk);
        check("t5_state", 32'(dut.state_q), 32'd0);
        check("t5_captured", 32'(dut.captured_q), 32'h0);
        idle(5);
        check("t5_vv", 32'(vv_cnt - vv_base), 32'd0);
        check("t5_perr", 32'(pe_cnt - pe_base), 32'd0);

        // Async reset after 3 of 4 digits captured
        show(0, P1, 16); show(1, P2, 16); show(2, P3, 16);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_value", 32'(bus.value), 32'h0);
        check("t6_rst_valid", 32'(bus.value_valid), 32'h0);
        check("t6_rst_blank", 32'(bus.blank_mask), 32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        mark();
        show(3, P9, 16);
        idle(10);
        check("t6_no_stale", 32'(vv_cnt - vv_base), 32'd0);
        show(0, P9, 16); show(1, P9, 16); show(2, P9, 16); show(3, P9, 16);
        idle(10);
        check("t6_vv", 32'(vv_cnt - vv_base), 32'd1);
        check("t6_value", 32'(bus.value), 32'h9999);
        check("t6_blank", 32'(bus.blank_mask), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
